axil_master_arb: RTL and testbench

AXIL_MASTER_ARB -- requirements
Module: axil_master_arb

---
 rtl/axil_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 33 +++
 rtl/axil_master_arb.sv | 136 +++++++++++++
 tb/tb_axil_master_arb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_arb_pkg.sv
// Shared types and AXI response codes for the two-requester AXI4-Lite master.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt    = req;
    last_d = last_q;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
    if (advance && (gnt != 2'b00)) begin
      last_d = gnt[1];
    end
  end

  // last_q = 1 after reset so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/axil_master_arb.sv
// AXI4-Lite master shared by two requesters, one transaction outstanding at a time.
module axil_master_arb
  import axil_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [1:0]                req_valid,
  input  logic [1:0]                req_write,
  input  logic [2*ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0]   req_wdata,
  output logic [1:0]                req_ready,
  output logic [1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_WIDTH-1:0]     AWADDR,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   WSTRB,
  output logic                      WVALID,
  input  logic                      WREADY,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY,
  output logic [ADDR_WIDTH-1:0]     ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RVALID,
  output logic                      RREADY
);

  state_e                  state_q;
  logic                    sel_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    aw_pend_q;
  logic                    w_pend_q;
  logic [1:0]              rsp_valid_q;
  logic                    rsp_err_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;

  logic                    idle;
  logic [1:0]              gnt;

  // Grants are only taken while idle and out of reset, so nothing is accepted mid-transaction.
  assign idle = (state_q == IDLE) && !ARESET;

  rr_arb2 u_arb (
    .clk     (ACLK),
    .rst     (ARESET),
    .req     (req_valid),
    .advance (idle),
    .gnt     (gnt)
  );

  assign req_ready = gnt & {2{idle}};
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  assign AWADDR  = addr_q;
  assign ARADDR  = addr_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = '1;
  assign AWVALID = (state_q == WR_REQ) && aw_pend_q;
  assign WVALID  = (state_q == WR_REQ) && w_pend_q;
  assign BREADY  = (state_q == WR_RESP);
  assign ARVALID = (state_q == RD_REQ);
  assign RREADY  = (state_q == RD_RESP);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (gnt != 2'b00) begin
            sel_q   <= gnt[1];
            addr_q  <= gnt[1] ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
            wdata_q <= gnt[1] ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
            if (req_write[gnt[1]]) begin
              state_q   <= WR_REQ;
              aw_pend_q <= 1'b1;
              w_pend_q  <= 1'b1;
            end else begin
              state_q <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          aw_pend_q <= aw_pend_q && !AWREADY;
          w_pend_q  <= w_pend_q && !WREADY;
          if ((!aw_pend_q || AWREADY) && (!w_pend_q || WREADY)) begin
            state_q <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (BVALID) begin
            rsp_valid_q <= sel_q ? 2'b10 : 2'b01;
            rsp_err_q   <= (BRESP != OKAY);
            state_q     <= IDLE;
          end
        end
        RD_REQ: begin
          if (ARREADY) begin
            state_q <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (RVALID) begin
            rsp_valid_q <= sel_q ? 2'b10 : 2'b01;
            rsp_err_q   <= (RRESP != OKAY);
            rsp_rdata_q <= RDATA;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master_arb.sv
// Directed bench for axil_master_arb: reset, contention, single/skewed/error transactions, reset mid-read.
module tb_axil_master_arb;

  localparam int AW = 4;
  localparam int DW = 32;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [1:0]      req_valid;
  logic [1:0]      req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [AW-1:0]   AWADDR;
  logic            AWVALID;
  logic            AWREADY;
  logic [DW-1:0]   WDATA;
  logic [DW/8-1:0] WSTRB;
  logic            WVALID;
  logic            WREADY;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;
  logic [AW-1:0]   ARADDR;
  logic            ARVALID;
  logic            ARREADY;
  logic [DW-1:0]   RDATA;
  logic [1:0]      RRESP;
  logic            RVALID;
  logic            RREADY;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axil_master_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge ACLK);
    #1;
  endtask

  task automatic mid();
    @(negedge ACLK);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".axi"}, {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 64'h0);
    chk({tag, ".req_ready"}, req_ready, 64'h0);
    chk({tag, ".rsp_valid"}, rsp_valid, 64'h0);
    chk({tag, ".rsp_err"}, rsp_err, 64'h0);
    chk({tag, ".rsp_rdata"}, rsp_rdata, 64'h0);
  endtask

  initial begin
    ARESET = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    AWREADY = 0; WREADY = 0; BRESP = 0; BVALID = 0;
    ARREADY = 0; RDATA = '0; RRESP = 0; RVALID = 0;
    nxt(); nxt();
    mid();
    chk_all_zero("reset");
    nxt();
    ARESET = 1'b0;

    // Contention: both write continuously on a zero-wait slave; expect grants 0,1,0,1.
    AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 2'b00;
    req_valid = 2'b11; req_write = 2'b11;
    req_addr = {4'd2, 4'd1}; req_wdata = {32'h2222_2222, 32'h1111_1111};
    for (int k = 0; k < 4; k++) begin
      mid();
      chk($sformatf("cont.grant%0d", k), req_ready, (k % 2 == 0) ? 64'h1 : 64'h2);
      if (k > 0) chk($sformatf("cont.rsp%0d", k - 1), rsp_valid, (k % 2 == 1) ? 64'h1 : 64'h2);
      nxt();
      if (k == 3) req_valid = 2'b00;
      mid();
      chk($sformatf("cont.busy%0d", k), req_ready, 64'h0);
      nxt(); nxt();
    end
    mid();
    chk("cont.rsp3", rsp_valid, 64'h2);
    nxt();

    // Single write, requester 0, zero-wait slave: response 3 cycles after request.
    req_valid = 2'b01; req_write = 2'b01; req_addr = {4'd0, 4'd4}; req_wdata = {32'h0, 32'hA5A5_0001};
    mid();
    chk("wr.req_ready", req_ready, 64'h1);
    nxt();
    req_valid = 2'b00;
    mid();
    chk("wr.valids", {AWVALID, WVALID}, 64'h3);
    chk("wr.awaddr", AWADDR, 64'h4);
    chk("wr.wdata", WDATA, 64'hA5A5_0001);
    chk("wr.wstrb", WSTRB, 64'hF);
    chk("wr.bready_early", BREADY, 64'h0);
    nxt();
    mid();
    chk("wr.bready", BREADY, 64'h1);
    chk("wr.aw_dropped", {AWVALID, WVALID}, 64'h0);
    chk("wr.no_rsp_yet", rsp_valid, 64'h0);
    nxt();
    mid();
    chk("wr.rsp_valid", rsp_valid, 64'h1);
    chk("wr.rsp_err", rsp_err, 64'h0);
    nxt();
    mid();
    chk("wr.rsp_pulse", rsp_valid, 64'h0);
    BVALID = 0; AWREADY = 0; WREADY = 0;
    nxt();

    // Single read, requester 1.
    ARREADY = 1; RVALID = 1; RDATA = 32'h1234_5678; RRESP = 2'b00;
    req_valid = 2'b10; req_write = 2'b00; req_addr = {4'd8, 4'd0};
    mid();
    chk("rd.req_ready", req_ready, 64'h2);
    nxt();
    req_valid = 2'b00;
    mid();
    chk("rd.arvalid", ARVALID, 64'h1);
    chk("rd.araddr", ARADDR, 64'h8);
    chk("rd.rready_early", RREADY, 64'h0);
    nxt();
    mid();
    chk("rd.rready", RREADY, 64'h1);
    chk("rd.ar_dropped", ARVALID, 64'h0);
    nxt();
    mid();
    chk("rd.rsp_valid", rsp_valid, 64'h2);
    chk("rd.rsp_rdata", rsp_rdata, 64'h1234_5678);
    chk("rd.rsp_err", rsp_err, 64'h0);
    ARREADY = 0; RVALID = 0;
    nxt();

    // Skewed write: AWREADY in cycle 1, WREADY in cycle 4.
    req_valid = 2'b01; req_write = 2'b01; req_addr = {4'd0, 4'd6}; req_wdata = {32'h0, 32'h0BAD_F00D};
    mid();
    chk("skew.req_ready", req_ready, 64'h1);
    nxt();
    req_valid = 2'b00; AWREADY = 1;
    mid();
    chk("skew.c1", {AWVALID, WVALID}, 64'h3);
    nxt();
    AWREADY = 0;
    for (int c = 2; c <= 3; c++) begin
      mid();
      chk($sformatf("skew.c%0d", c), {AWVALID, WVALID, BREADY}, 64'h2);
      chk($sformatf("skew.wdata%0d", c), WDATA, 64'h0BAD_F00D);
      nxt();
    end
    WREADY = 1;
    mid();
    chk("skew.c4", {AWVALID, WVALID, BREADY}, 64'h2);
    nxt();
    WREADY = 0; BVALID = 1;
    mid();
    chk("skew.c5", {AWVALID, WVALID, BREADY}, 64'h1);
    nxt();
    BVALID = 0;
    mid();
    chk("skew.rsp_valid", rsp_valid, 64'h1);
    nxt();

    // Error responses: SLVERR on write, DECERR on read.
    AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 2'b10;
    req_valid = 2'b01; req_write = 2'b01; req_addr = {4'd0, 4'd2};
    nxt();
    req_valid = 2'b00;
    nxt(); nxt();
    mid();
    chk("err.wr_rsp_valid", rsp_valid, 64'h1);
    chk("err.wr_rsp_err", rsp_err, 64'h1);
    nxt();
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 2'b00;
    ARREADY = 1; RVALID = 1; RDATA = 32'hDEAD_BEEF; RRESP = 2'b11;
    req_valid = 2'b10; req_write = 2'b00; req_addr = {4'd3, 4'd0};
    nxt();
    req_valid = 2'b00;
    nxt(); nxt();
    mid();
    chk("err.rd_rsp_valid", rsp_valid, 64'h2);
    chk("err.rd_rsp_err", rsp_err, 64'h1);
    chk("err.rd_rdata", rsp_rdata, 64'hDEAD_BEEF);
    nxt();

    // Reset mid-read: requester 0 read stalls in RD_RESP, reset, next tie must go to requester 0.
    RVALID = 0; RRESP = 2'b00; RDATA = 32'h5555_AAAA;
    req_valid = 2'b01; req_write = 2'b00; req_addr = {4'd0, 4'hC};
    mid();
    chk("rst.req_ready", req_ready, 64'h1);
    nxt();
    req_valid = 2'b00;
    mid();
    chk("rst.arvalid", ARVALID, 64'h1);
    nxt();
    ARESET = 1'b1;
    mid();
    chk("rst.rready", RREADY, 64'h1);
    nxt();
    ARESET = 1'b0; RVALID = 1;
    mid();
    chk_all_zero("rst.after");
    nxt();
    req_valid = 2'b11;
    mid();
    chk("rst.no_rsp", rsp_valid, 64'h0);
    chk("rst.tie_to_0", req_ready, 64'h1);
    nxt();
    req_valid = 2'b00;
    nxt(); nxt(); nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Never a double grant or double response.
  always @(negedge ACLK) begin
    if (!ARESET && (req_ready == 2'b11 || rsp_valid == 2'b11)) begin
      checks++;
      errors++;
      $error("FAIL onehot observed=%0h/%0h expected=not-both", req_ready, rsp_valid);
    end
  end

endmodule
